// File: rtl/lcd_msg_formatter.sv
// lcd_msg_formatter: latches a display mode and two binary cent amounts,
// converts both to BCD with a shared-schedule double-dabble, then streams a
// complete 2x16 ASCII frame to the LCD driver over a valid/ready link.
// Optional feature macro: LCD_LZB_EN (leading-zero blanking of integer digits).
module lcd_msg_formatter #(
  parameter int VAL_W       = 14,
  parameter int INT_DIGITS  = 2,
  parameter int FRAC_DIGITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [VAL_W-1:0] val_a,
  input  logic [VAL_W-1:0] val_b,
  input  logic             update,
  output logic             busy,
  output logic             char_valid,
  input  logic             char_ready,
  output logic [7:0]       char_data,
  output logic [4:0]       char_addr,
  output logic             frame_done
);
  localparam int ND     = INT_DIGITS + FRAC_DIGITS;
  localparam int FW     = ND + 1;
  localparam int FSTART = 16 - FW;
  localparam int EQCOL  = 15 - FW;
  localparam int CW     = $clog2(VAL_W + 1);

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] LIMIT = pow10(ND);

  localparam logic [127:0] T_BLANK  = "                ";
  localparam logic [127:0] T_INSERT = "INSERT COIN     ";
  localparam logic [127:0] T_SOLD   = "SOLD OUT        ";
  localparam logic [127:0] T_OWED   = "price owed      ";
  localparam logic [127:0] T_PAID   = "price paid      ";
  localparam logic [127:0] T_CHANGE = "change          ";
  localparam logic [127:0] T_THANK  = "thank you       ";

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_SEND, S_DONE} state_t;

  state_t            r_state;
  logic [1:0]        r_mode;
  logic [VAL_W-1:0]  r_bin_a, r_bin_b;
  logic [4*ND-1:0]   r_bcd_a, r_bcd_b;
  logic              r_sat_a, r_sat_b;
  logic              r_pend;
  logic [CW-1:0]     r_cnt;

  logic [4*ND-1:0]   w_adj_a, w_adj_b, w_bcd;
  logic [4:0]        w_addr;
  logic [3:0]        w_col;
  logic              w_row, w_fld, w_sat;
  logic [127:0]      w_txt;
  logic [7:0]        w_char;

  // Add 3 to every BCD digit >= 5 ahead of the shift.
  function automatic logic [4*ND-1:0] add3(input logic [4*ND-1:0] b);
    logic [4*ND-1:0] r;
    r = b;
    for (int unsigned i = 0; i < ND; i++)
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    return r;
  endfunction

  // One character of the right-justified numeric field at column col.
  function automatic logic [7:0] field_char(input logic [3:0] col,
                                            input logic [4*ND-1:0] bcd,
                                            input logic sat);
    int unsigned p, d;
    logic [7:0]  c;
    p = 32'(col) - 32'(FSTART);
    c = 8'h2E;
    if (p != INT_DIGITS) begin
      d = (p < INT_DIGITS) ? p : p - 1;
      if (sat) c = "9";
      else     c = 8'h30 + 8'(bcd[4*(ND-1-d) +: 4]);
`ifdef LCD_LZB_EN
      if (!sat && p + 1 < INT_DIGITS) begin
        logic lead;
        lead = 1'b1;
        for (int unsigned k = 0; k < INT_DIGITS; k++)
          if (k <= p && bcd[4*(ND-1-k) +: 4] != 4'd0) lead = 1'b0;
        if (lead) c = " ";
      end
`endif
    end
    return c;
  endfunction

  // Digit correction for both conversions running in lockstep.
  always_comb begin
    w_adj_a = add3(r_bcd_a);
    w_adj_b = add3(r_bcd_b);
  end

  // Character for the next address to be presented. Outside SEND this is
  // address 0, a label column, so it never depends on unfinished BCD.
  always_comb begin
    w_addr = (r_state == S_SEND) ? char_addr + 5'd1 : '0;
    w_col  = w_addr[3:0];
    w_row  = w_addr[4];
    w_bcd  = w_row ? r_bcd_b : r_bcd_a;
    w_sat  = w_row ? r_sat_b : r_sat_a;
    w_fld  = 1'b0;
    w_txt  = T_BLANK;
    unique case (r_mode)
      2'd0:    w_txt = w_row ? T_BLANK : T_INSERT;
      2'd1:    begin w_txt = w_row ? T_PAID : T_OWED;    w_fld = 1'b1;   end
      2'd2:    begin w_txt = w_row ? T_THANK : T_CHANGE; w_fld = !w_row; end
      default: w_txt = w_row ? T_BLANK : T_SOLD;
    endcase
    if (w_fld && 32'(w_col) >= 32'(FSTART))
      w_char = field_char(w_col, w_bcd, w_sat);
    else if (w_fld && 32'(w_col) == 32'(EQCOL))
      w_char = "=";
    else
      w_char = w_txt[8*(4'd15 - w_col) +: 8];
  end

  // Control FSM: latch, convert, stream 32 characters, signal completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_mode     <= '0;
      r_bin_a    <= '0;
      r_bin_b    <= '0;
      r_bcd_a    <= '0;
      r_bcd_b    <= '0;
      r_sat_a    <= 1'b0;
      r_sat_b    <= 1'b0;
      r_pend     <= 1'b0;
      r_cnt      <= '0;
      busy       <= 1'b0;
      char_valid <= 1'b0;
      char_data  <= '0;
      char_addr  <= '0;
      frame_done <= 1'b0;
    end else begin
      if (r_state != S_IDLE) r_pend <= r_pend | update;
      unique case (r_state)
        S_IDLE: begin
          if (update || r_pend) begin
            r_mode  <= mode;
            r_bin_a <= val_a;
            r_bin_b <= val_b;
            r_sat_a <= 64'(val_a) >= LIMIT;
            r_sat_b <= 64'(val_b) >= LIMIT;
            r_bcd_a <= '0;
            r_bcd_b <= '0;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
            busy    <= 1'b1;
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          {r_bcd_a, r_bin_a} <= {w_adj_a, r_bin_a} << 1;
          {r_bcd_b, r_bin_b} <= {w_adj_b, r_bin_b} << 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(VAL_W - 1)) begin
            char_valid <= 1'b1;
            char_addr  <= '0;
            char_data  <= w_char;
            r_state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (char_ready) begin
            if (char_addr == 5'd31) begin
              char_valid <= 1'b0;
              char_data  <= '0;
              char_addr  <= '0;
              frame_done <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              char_addr <= w_addr;
              char_data <= w_char;
            end
          end
        end
        default: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_msg_formatter.sv
// Testbench for lcd_msg_formatter: table of spec frames, pending/reset
// sequences, and randomized frames against a string-building reference model.
module tb_lcd_msg_formatter;
  localparam int VAL_W = 14;
  localparam int INTD  = 2;
  localparam int FRACD = 2;
  localparam int FW    = INTD + FRACD + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       mode;
  logic [VAL_W-1:0] val_a, val_b;
  logic             update;
  logic             busy, char_valid, char_ready, frame_done;
  logic [7:0]       char_data;
  logic [4:0]       char_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lcd_msg_formatter #(.VAL_W(VAL_W), .INT_DIGITS(INTD), .FRAC_DIGITS(FRACD)) dut (
    .clk(clk), .rst(rst), .mode(mode), .val_a(val_a), .val_b(val_b),
    .update(update), .busy(busy), .char_valid(char_valid),
    .char_ready(char_ready), .char_data(char_data), .char_addr(char_addr),
    .frame_done(frame_done)
  );

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_s(input string nm, input string got, input string exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", nm, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic string pad(input string s, input int n);
    string r;
    r = s;
    while (r.len() < n) r = {r, " "};
    return r;
  endfunction

  function automatic string fld(input int v);
    string s;
    int n, lim;
    n = INTD + FRACD;
    lim = 1;
    for (int i = 0; i < n; i++) lim *= 10;
    s = "";
    for (int i = 0; i < n; i++) begin
      int w;
      w = 1;
      for (int k = 0; k < n - 1 - i; k++) w *= 10;
      if (i == INTD) s = {s, "."};
      s = $sformatf("%s%0d", s, (v >= lim) ? 9 : (v / w) % 10);
    end
`ifdef LCD_LZB_EN
    for (int i = 0; i < INTD - 1; i++) begin
      if (s[i] != "0") break;
      s.putc(i, " ");
    end
`endif
    return s;
  endfunction

  function automatic string lab(input string l, input int v);
    return {pad(l, 15 - FW), "=", fld(v)};
  endfunction

  function automatic string model_frame(input int m, input int a, input int b);
    case (m)
      0:       return {pad("INSERT COIN", 16), pad("", 16)};
      1:       return {lab("price owed", a), lab("price paid", b)};
      2:       return {lab("change", a), pad("thank you", 16)};
      default: return {pad("SOLD OUT", 16), pad("", 16)};
    endcase
  endfunction

  // ---------------- frame runner ----------------
  // Called at a negedge ("cycle 0"). start drives the update pulse there;
  // inj_at 0..31 pulses update with val_a=inj_a when that addr is shown,
  // 32 pulses it during the frame_done cycle. Returns at the negedge of the
  // cycle after frame_done.
  task automatic run_frame(input bit start, input int m, input int a, input int b,
                           input bit rnd, input int inj_at, input int inj_a,
                           input string tag, output string got);
    int first_v, ntx, last_tx, done_cyc;
    bit order_ok, stall_ok, injected, pv, pr;
    logic [7:0] pd;
    logic [4:0] pa;
    got = pad("", 32);
    first_v = -1; ntx = 0; last_tx = -1; done_cyc = -1;
    order_ok = 1; stall_ok = 1; injected = 0; pv = 0; pr = 0; pd = '0; pa = '0;
    if (start) begin
      mode = 2'(m); val_a = VAL_W'(a); val_b = VAL_W'(b); update = 1'b1;
    end
    for (int cyc = 1; cyc < 600 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      update = 1'b0;
      if (cyc == 1) chk({tag, " busy_next_cycle"}, int'(busy), 1);
      if (cyc == 2 && inj_at < 0) begin
        mode = 2'($urandom); val_a = VAL_W'($urandom); val_b = VAL_W'($urandom);
      end
      if (pv && !pr && !(char_valid && char_data == pd && char_addr == pa)) stall_ok = 0;
      if (frame_done) begin
        done_cyc = cyc;
        if (inj_at == 32 && !injected) begin
          val_a = VAL_W'(inj_a); update = 1'b1; injected = 1;
        end
      end
      if (char_valid) begin
        if (first_v < 0) first_v = cyc;
        if (inj_at == int'(char_addr) && !injected) begin
          val_a = VAL_W'(inj_a); update = 1'b1; injected = 1;
        end
      end
      char_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (char_valid && char_ready) begin
        if (int'(char_addr) != ntx) order_ok = 0;
        got.putc(int'(char_addr), char_data);
        ntx++;
        last_tx = cyc;
      end
      pv = char_valid; pr = char_ready; pd = char_data; pa = char_addr;
    end
    if (done_cyc < 0) begin
      checks++; errors++;
      $display("FAIL %s timeout: frame_done not seen within 600 cycles", tag);
    end
    chk({tag, " first_valid_cycle"}, first_v, VAL_W + 1);
    chk({tag, " transfers"}, ntx, 32);
    chk({tag, " addr_order"}, int'(order_ok), 1);
    chk({tag, " stall_hold"}, int'(stall_ok), 1);
    chk({tag, " done_after_31"}, done_cyc, last_tx + 1);
    @(negedge clk);
    update = 1'b0;
    chk({tag, " after_done busy/done/valid"}, int'({busy, frame_done, char_valid}), 0);
  endtask

  typedef struct {
    int    m;
    int    a;
    int    b;
    bit    rnd;
    string name;
    string exp;
  } vec_t;

  vec_t  vecs[7];
  string got, r1_case1, b16;

  initial begin
    b16 = {"        ", "        "};
`ifdef LCD_LZB_EN
    r1_case1 = "price paid= 5.00";
`else
    r1_case1 = "price paid=05.00";
`endif
    vecs[0] = '{1, 1234,   500, 0, "case1 mode1",       {"price owed=12.34", r1_case1}};
    vecs[1] = '{2, 12000,  0,   0, "case2 sat change",  {"change    =99.99", "thank you       "}};
    vecs[2] = '{3, 77,     88,  0, "case2 sold out",    {"SOLD OUT        ", b16}};
    vecs[3] = '{1, 1234,   500, 1, "case3 rnd ready",   {"price owed=12.34", r1_case1}};
    vecs[4] = '{0, 5,      6,   1, "case6 insert coin", {"INSERT COIN     ", b16}};
    vecs[5] = '{1, 9999, 10000, 1, "boundary 9999/10000", {"price owed=99.99", "price paid=99.99"}};
`ifdef LCD_LZB_EN
    vecs[6] = '{2, 0,      0,   0, "zero change",       {"change    = 0.00", "thank you       "}};
`else
    vecs[6] = '{2, 0,      0,   0, "zero change",       {"change    =00.00", "thank you       "}};
`endif

    rst = 1'b1; update = 1'b0; char_ready = 1'b0; mode = '0; val_a = '0; val_b = '0;
    repeat (3) @(negedge clk);
    chk("reset outputs", int'({busy, char_valid, char_data, char_addr, frame_done}), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_frame(1'b1, vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].rnd, -1, 0, vecs[i].name, got);
      chk_s({vecs[i].name, " frame"}, got, vecs[i].exp);
    end

    // update mid-frame at addr 10: frame 1 unchanged, pending frame follows
    run_frame(1'b1, 1, 1234, 500, 1'b0, 10, 75, "case4 frame1", got);
    chk_s("case4 frame1 content", got, {"price owed=12.34", r1_case1});
`ifdef LCD_LZB_EN
    run_frame(1'b0, 1, 75, 500, 1'b0, -1, 0, "case4 frame2", got);
    chk_s("case4 frame2 content", got, {"price owed= 0.75", r1_case1});
`else
    run_frame(1'b0, 1, 75, 500, 1'b0, -1, 0, "case4 frame2", got);
    chk_s("case4 frame2 content", got, {"price owed=00.75", r1_case1});
`endif

    // update coinciding with frame_done counts as pending
    run_frame(1'b1, 2, 300, 0, 1'b1, 32, 5, "done-upd frame1", got);
    chk_s("done-upd frame1 content", got, model_frame(2, 300, 0));
    run_frame(1'b0, 2, 5, 0, 1'b0, -1, 0, "done-upd frame2", got);
    chk_s("done-upd frame2 content", got, model_frame(2, 5, 0));

    // asynchronous reset at addr 20, with a pending request that must be dropped
    begin
      bit hit;
      hit = 0;
      mode = 2'd1; val_a = VAL_W'(1234); val_b = VAL_W'(500); update = 1'b1; char_ready = 1'b1;
      for (int c = 0; c < 200 && !hit; c++) begin
        @(negedge clk);
        update = 1'b0;
        if (char_valid && char_addr == 5'd5) update = 1'b1;
        if (char_valid && char_addr == 5'd20) hit = 1;
      end
      chk("case5 reached addr 20", int'(hit), 1);
      #2 rst = 1'b1;
      #1 chk("case5 async reset outputs", int'({busy, char_valid, char_data, char_addr, frame_done}), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("case5 pending cleared", int'(busy), 0);
      run_frame(1'b1, 1, 1234, 500, 1'b0, -1, 0, "case5 post-reset", got);
      chk_s("case5 post-reset content", got, {"price owed=12.34", r1_case1});
    end

    // randomized frames against the reference model
    for (int t = 0; t < 10; t++) begin
      int m, a, b, r;
      m = int'($urandom_range(0, 3));
      r = int'($urandom_range(0, 9));
      a = (r < 2) ? int'($urandom_range(10000, 16383)) : (r == 2) ? 9999 : int'($urandom_range(0, 9999));
      r = int'($urandom_range(0, 9));
      b = (r < 2) ? int'($urandom_range(10000, 16383)) : (r == 2) ? 0 : int'($urandom_range(0, 9999));
      run_frame(1'b1, m, a, b, 1'b1, -1, 0, $sformatf("rand%0d", t), got);
      chk_s($sformatf("rand%0d m%0d a%0d b%0d content", t, m, a, b), got, model_frame(m, a, b));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end
endmodule
